// File: rtl/sort_out_serializer_pkg.sv
// ============================================================================
// Module : sort_out_serializer_pkg
// Brief  : Shared sorter constants and serializer state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sort_out_serializer_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_N     = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sort_out_serializer_if.sv
// ============================================================================
// Module : sort_out_serializer_if
// Brief  : Vector-in / element-out handshake bundle for the sort serializer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sort_out_serializer_if #(
  parameter int WIDTH = 3,
  parameter int N     = 8
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   in_data;
  logic                 dir;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [IW-1:0]        out_idx;
  logic                 out_last;

  modport master (
    output in_valid, in_data, dir, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, dir, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

`default_nettype wire

// File: rtl/sort_out_serializer.sv
// ============================================================================
// Module : sort_out_serializer
// Brief  : Emits a pre-sorted N-element vector one element per handshake,
//          ascending or descending, with registered outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_out_serializer
  import sort_out_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input  wire logic              clk,
  input  wire logic              rst,
  sort_out_serializer_if.slave   bus,
  output logic [7:0]             vec_cnt
);

  localparam int            IW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] PTR_MAX = IW'(N - 1);

  state_e               state_q;
  logic [N*WIDTH-1:0]   hold_q;
  logic                 dir_q;
  logic [IW-1:0]        ptr_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [IW-1:0]        out_idx_q;
  logic [7:0]           vec_cnt_q;

  logic [IW-1:0]        ptr_d;
  logic [IW-1:0]        start_ptr_d;
  logic                 next_last_d;

  always_comb begin
    ptr_d       = dir_q ? (ptr_q - IW'(1)) : (ptr_q + IW'(1));
    start_ptr_d = bus.dir ? PTR_MAX : '0;
    next_last_d = (ptr_d == (dir_q ? '0 : PTR_MAX));
  end

  // Outputs are loaded one edge ahead so the element is valid in the cycle after its step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      dir_q       <= 1'b0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      vec_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            hold_q      <= bus.in_data;
            dir_q       <= bus.dir;
            ptr_q       <= start_ptr_d;
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data[int'(start_ptr_d)*WIDTH +: WIDTH];
            out_idx_q   <= start_ptr_d;
            out_last_q  <= (N == 1);
            state_q     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              vec_cnt_q   <= vec_cnt_q + 8'd1;
              state_q     <= ST_IDLE;
            end else begin
              ptr_q       <= ptr_d;
              out_data_q  <= hold_q[int'(ptr_d)*WIDTH +: WIDTH];
              out_idx_q   <= ptr_d;
              out_last_q  <= next_last_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign vec_cnt       = vec_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sort_out_serializer.sv
// ============================================================================
// Module : tb_sort_out_serializer
// Brief  : Randomized bench for sort_out_serializer against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sort_out_serializer;

  localparam int W = 3;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] vec_cnt;

  always #5 clk = ~clk;

  sort_out_serializer_if #(.WIDTH(W), .N(N)) bus ();

  sort_out_serializer #(.WIDTH(W), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .vec_cnt (vec_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of (value, index) pairs still to be emitted.
  bit m_busy;
  int q_data[$];
  int q_idx[$];
  int m_cnt;
  int m_last_d;
  int m_last_i;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    q_data.delete();
    q_idx.delete();
    m_cnt    = 0;
    m_last_d = 0;
    m_last_i = 0;
  endtask

  task automatic check_outputs();
    chk("in_ready",  int'(bus.in_ready),  int'(!m_busy));
    chk("out_valid", int'(bus.out_valid), int'(m_busy));
    if (m_busy) begin
      chk("out_data", int'(bus.out_data), q_data[0]);
      chk("out_idx",  int'(bus.out_idx),  q_idx[0]);
      chk("out_last", int'(bus.out_last), int'(q_data.size() == 1));
    end else begin
      chk("hold_data", int'(bus.out_data), m_last_d);
      chk("hold_idx",  int'(bus.out_idx),  m_last_i);
      chk("out_last",  int'(bus.out_last), 0);
    end
    chk("vec_cnt", int'(vec_cnt), m_cnt);
  endtask

  task automatic model_edge();
    logic [N*W-1:0] v;
    if (!m_busy) begin
      if (bus.in_valid) begin
        v = bus.in_data;
        for (int k = 0; k < N; k++) begin
          int e;
          e = bus.dir ? (N - 1 - k) : k;
          q_idx.push_back(e);
          q_data.push_back(int'((v >> (e * W)) & ((1 << W) - 1)));
        end
        m_busy = 1'b1;
      end
    end else if (bus.out_ready) begin
      m_last_d = q_data.pop_front();
      m_last_i = q_idx.pop_front();
      if (q_data.size() == 0) begin
        m_busy = 1'b0;
        m_cnt  = (m_cnt + 1) % 256;
      end
    end
  endtask

  // Entered and left on a falling edge: check, drive, clock, advance model.
  task automatic cycle(input bit iv, input logic [N*W-1:0] d, input bit dr, input bit rdy);
    check_outputs();
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.dir       = dr;
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [N*W-1:0] rand_sorted();
    int q[$];
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) q.push_back(int'($urandom_range(0, (1 << W) - 1)));
    q.sort();
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(q[k]);
    return v;
  endfunction

  localparam logic [N*W-1:0] VEC_RAMP = 24'hFAC688;  // elements 0..7 ascending

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.dir       = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b1;

    // Ascending then descending ramp with free-flowing output.
    cycle(1'b1, VEC_RAMP, 1'b0, 1'b1);
    repeat (N + 1) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, VEC_RAMP, 1'b1, 1'b1);
    repeat (N + 1) cycle(1'b0, '0, 1'b0, 1'b1);

    // Backpressure pattern 1,0,0,1 with dir flipping mid-vector.
    cycle(1'b1, rand_sorted(), 1'b0, 1'b1);
    for (int i = 0; i < 4 * N; i++)
      cycle(1'b0, '0, bit'(i % 2), (i % 4 == 0) || (i % 4 == 3));

    // in_valid held high with changing data throughout emission.
    for (int i = 0; i < 3 * (N + 1); i++)
      cycle(1'b1, rand_sorted(), bit'($urandom_range(0, 1)), 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      cycle(bit'($urandom_range(0, 1)), rand_sorted(),
            bit'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));

    // Mid-vector reset after the third element has been accepted.
    repeat (N + 2) cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, rand_sorted(), 1'b0, 1'b1);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 256 full vectors so the counter wraps back to zero.
    for (int v = 0; v < 256; v++) begin
      cycle(1'b1, rand_sorted(), bit'($urandom_range(0, 1)), 1'b1);
      repeat (N) cycle(1'b0, '0, 1'b0, 1'b1);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("vec_cnt_wrap", int'(vec_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sort_out_serializer.md
SORT_OUT_SERIALIZER -- requirements
Module: sort_out_serializer

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 3, bits per element.
- N, default 8, elements per sorted vector.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, reset; asynchronous, active-low.
- in_valid, input, 1, sorted vector present on in_data.
- in_ready, output, 1, block can accept a vector.
- in_data, input, N*WIDTH, 8-element sorted vector; element k in bits [(k+1)*WIDTH-1 : k*WIDTH]; element 0 is the smallest.
- dir, input, 1, 0 = emit ascending, 1 = emit descending; sampled on the input handshake.
- out_valid, output, 1, out_data holds an element.
- out_ready, input, 1, downstream accepts the element.
- out_data, output, WIDTH, current element.
- out_idx, output, 3, vector index k of the current element.
- out_last, output, 1, current element is the final element of the vector.
- vec_cnt, output, 8, count of vectors fully emitted.

Function
REQ-003 The block SHALL implement a two-state FSM, IDLE and EMIT; IDLE is the reset state.
REQ-004 in_ready SHALL be 1 exactly when the state is IDLE.
REQ-005 In IDLE, on in_valid=1, the block SHALL in the same edge:
- capture in_data into an N*WIDTH holding register;
- latch dir;
- load the element pointer with 0 (dir=0) or N-1 (dir=1);
- move to EMIT.
REQ-006 In EMIT, out_valid SHALL be 1, out_data SHALL equal held element[pointer], and out_idx SHALL equal the pointer.
REQ-007 Latency: the first element SHALL appear with out_valid=1 in the cycle after the input handshake.
REQ-008 On an out_valid & out_ready cycle, the pointer SHALL step by +1 (dir=0) or -1 (dir=1); with out_ready=0, all outputs SHALL hold unchanged.
REQ-009 out_last SHALL be 1 in EMIT exactly when the pointer is at its final value: N-1 for dir=0, 0 for dir=1.
REQ-010 On the handshake of the out_last element, the FSM SHALL return to IDLE and vec_cnt SHALL increment by 1, wrapping from 255 to 0.
REQ-011 Throughput SHALL be one vector per N+1 cycles with out_ready held at 1; there is exactly one IDLE bubble cycle between vectors.
REQ-012 While in EMIT, in_valid and in_data SHALL be ignored and the holding register SHALL NOT change.
REQ-013 A change of dir during EMIT SHALL have no effect until the next input handshake.
REQ-014 In IDLE, out_valid SHALL be 0 and out_last SHALL be 0; out_data and out_idx SHALL hold their last values.
REQ-015 The block SHALL NOT reorder or check elements; input is trusted to be already sorted.

Reset
REQ-016 Asserting rst (rst=0) SHALL force, immediately:
- state = IDLE;
- out_valid = 0, out_last = 0;
- out_data = 0, out_idx = 0;
- vec_cnt = 0;
- pointer = 0, holding register = 0.
As a result in_ready = 1.
REQ-017 A reset asserted mid-vector SHALL discard the remaining elements and SHALL NOT increment vec_cnt.
REQ-018 After rst deasserts, the first input handshake SHALL be accepted on the first rising edge with in_valid=1.

Structure
REQ-019 The shared sorter package SHALL hold:
- the IDLE/EMIT state encoding;
- the default WIDTH=3 and N=8 constants.
REQ-020 The block SHALL be a single module with the element mux inline; no sub-module is required.
REQ-021 The block SHALL be synthesizable, with no latches and no combinational path from in_valid to out_*.

Verification (WIDTH=3, N=8)
REQ-022 Ascending: in_data = {7,6,5,4,3,2,1,0}, dir=0, out_ready=1 -> out_data 0..7 on consecutive cycles, out_idx 0..7, out_last only with 7, vec_cnt=1.
REQ-023 Descending: same vector, dir=1 -> out_data 7..0, out_idx 7..0, out_last with 0.
REQ-024 Backpressure: out_ready toggled 1,0,0,1,... -> no element dropped or duplicated; out_data/out_idx stable while stalled.
REQ-025 Ignored input: in_valid held 1 with changing data during EMIT -> emitted sequence equals the captured vector only; next capture happens after the out_last handshake plus one cycle.
REQ-026 Reset and wrap:
- rst=0 after the third element -> out_valid=0 immediately, vec_cnt=0.
- 256 vectors emitted -> vec_cnt wraps to 0.
